alu_issue_ctrl: RTL and testbench

//  Execute-stage initiator for the ALU sel/ready interface. Accepts one decoded RV32IM
//  OP/OP-IMM instruction per handshake, maps it to a 5-bit ALU select, and holds operands

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_op_decode.sv | 52 +++++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU select codes, RV32 opcode
// and funct7 constants, and issue FSM states.
package alu_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'h00,
      ALU_SLL  = 5'h01,
      ALU_SLT  = 5'h02,
      ALU_SLTU = 5'h03,
      ALU_XOR  = 5'h04,
      ALU_SRL  = 5'h05,
      ALU_OR   = 5'h06,
      ALU_AND  = 5'h07,
      ALU_SUB  = 5'h08,
      ALU_SRA  = 5'h0D,
      ALU_MUL  = 5'h1E
   } alu_sel_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MD_START,
      ST_MD_WAIT,
      ST_RESP
   } issue_state_e;

   // Select for the funct7=0 form of each funct3 (shared by OP and OP-IMM).
   function automatic alu_sel_e base_sel(input logic [2:0] f3);
      case (f3)
         3'b000: return ALU_ADD;
         3'b001: return ALU_SLL;
         3'b010: return ALU_SLT;
         3'b011: return ALU_SLTU;
         3'b100: return ALU_XOR;
         3'b101: return ALU_SRL;
         3'b110: return ALU_OR;
         3'b111: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32IM OP/OP-IMM decode into an ALU select, operand-B source
// and an illegal flag.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output alu_sel_e   sel,
   output logic       use_imm,
   output logic       illegal
);

   always_comb begin
      sel     = ALU_ADD;
      use_imm = 1'b0;
      illegal = 1'b0;
      if (opcode == OPC_OP) begin
         case (funct7)
            F7_ZERO:   sel = base_sel(funct3);
            F7_ALT: begin
               if (funct3 == 3'b000)      sel = ALU_SUB;
               else if (funct3 == 3'b101) sel = ALU_SRA;
               else                       illegal = 1'b1;
            end
            F7_MULDIV: begin
               if (funct3 == 3'b000) sel = ALU_MUL;
               else                  illegal = 1'b1;
            end
            default:   illegal = 1'b1;
         endcase
      end else if (opcode == OPC_OPIMM) begin
         use_imm = 1'b1;
         // Only the shift immediates carry a funct7 field; elsewhere it is imm[11:5].
         case (funct3)
            3'b001: begin
               sel = ALU_SLL;
               if (funct7 != F7_ZERO) illegal = 1'b1;
            end
            3'b101: begin
               if (funct7 == F7_ZERO)     sel = ALU_SRL;
               else if (funct7 == F7_ALT) sel = ALU_SRA;
               else                       illegal = 1'b1;
            end
            default: sel = base_sel(funct3);
         endcase
      end else begin
         illegal = 1'b1;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: accepts one decoded op, drives the ALU
// sel/ready interface (single-cycle ops and multi-cycle MUL), returns the result.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int          XLEN       = 32,
   parameter int          MD_TIMEOUT = 64,
   parameter logic [4:0]  IDLE_SEL   = 5'h00
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic [6:0]      in_funct7,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_rs1_val,
   input  logic [XLEN-1:0] in_rs2_val,
   input  logic [XLEN-1:0] in_imm,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [4:0]      alu_sel,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_result,
   output logic            out_illegal,
   output logic            out_timeout,
   output logic            busy
);

   localparam int CW = $clog2(MD_TIMEOUT + 1);

   issue_state_e state;
   logic [CW-1:0] cnt;
   alu_sel_e     dec_sel;
   logic         dec_use_imm;
   logic         dec_illegal;
   logic         accept;

   alu_op_decode u_dec (
      .opcode  (in_opcode),
      .funct3  (in_funct3),
      .funct7  (in_funct7),
      .sel     (dec_sel),
      .use_imm (dec_use_imm),
      .illegal (dec_illegal)
   );

   assign in_ready = (state == ST_IDLE) || ((state == ST_RESP) && out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_sel     <= IDLE_SEL;
         out_valid   <= 1'b0;
         out_rd      <= '0;
         out_result  <= '0;
         out_illegal <= 1'b0;
         out_timeout <= 1'b0;
      end else begin
         case (state)
            ST_EXEC: begin
               out_result <= alu_result;
               out_valid  <= 1'b1;
               alu_sel    <= IDLE_SEL;
               state      <= ST_RESP;
            end
            ST_MD_START: begin
               // alu_ready here may be a leftover done from the previous MUL.
               cnt   <= '0;
               state <= ST_MD_WAIT;
            end
            ST_MD_WAIT: begin
               if (alu_ready) begin
                  out_result <= alu_result;
                  out_valid  <= 1'b1;
                  alu_sel    <= IDLE_SEL;
                  state      <= ST_RESP;
               end else if (cnt == CW'(MD_TIMEOUT - 1)) begin
                  out_result  <= '0;
                  out_timeout <= 1'b1;
                  out_valid   <= 1'b1;
                  alu_sel     <= IDLE_SEL;
                  state       <= ST_RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_RESP: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  out_illegal <= 1'b0;
                  out_timeout <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: ;
         endcase

         // Accept is shared by IDLE and the RESP handshake cycle; it overrides the above.
         if (accept) begin
            out_rd <= in_rd;
            if (dec_illegal) begin
               out_result  <= '0;
               out_illegal <= 1'b1;
               out_valid   <= 1'b1;
               state       <= ST_RESP;
            end else begin
               alu_a   <= in_rs1_val;
               alu_b   <= dec_use_imm ? in_imm : in_rs2_val;
               alu_sel <= dec_sel;
               state   <= (dec_sel == ALU_MUL) ? ST_MD_START : ST_EXEC;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed-vector bench for alu_issue_ctrl with a behavioural ALU/multiplier
// on the sel/ready interface.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd;
   logic [31:0] in_rs1_val, in_rs2_val, in_imm;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [4:0]  alu_sel;
   logic        alu_ready;
   logic        out_valid, out_ready;
   logic [4:0]  out_rd;
   logic [31:0] out_result;
   logic        out_illegal, out_timeout, busy;

   logic        mul_ready;
   logic        mul_stale;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          lat;
   int          low_run  = 0;
   int          last_gap = -1;
   logic        prev_hi  = 1'b0;

   alu_issue_ctrl #(.XLEN(32), .MD_TIMEOUT(64), .IDLE_SEL(5'h0F)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_ready(alu_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rd(out_rd), .out_result(out_result),
      .out_illegal(out_illegal), .out_timeout(out_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   // ALU environment: single-cycle ops always ready; MUL ready is bench-driven.
   always_comb begin
      case (alu_sel)
         5'h00:   alu_result = alu_a + alu_b;
         5'h08:   alu_result = alu_a - alu_b;
         5'h01:   alu_result = alu_a << alu_b[4:0];
         5'h02:   alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         5'h03:   alu_result = {31'd0, alu_a < alu_b};
         5'h04:   alu_result = alu_a ^ alu_b;
         5'h05:   alu_result = alu_a >> alu_b[4:0];
         5'h0D:   alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         5'h06:   alu_result = alu_a | alu_b;
         5'h07:   alu_result = alu_a & alu_b;
         default: alu_result = mul_stale ? 32'hDEAD_BEEF : alu_a * alu_b;
      endcase
      alu_ready = alu_sel[4] ? mul_ready : 1'b1;
   end

   // Length of the low run on alu_sel[4] preceding each MUL start.
   always @(negedge clk) begin
      prev_hi <= alu_sel[4];
      if (alu_sel[4]) low_run <= 0;
      else            low_run <= low_run + 1;
      if (alu_sel[4] && !prev_hi) last_gap <= low_run;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm);
      in_opcode  = opc;  in_funct3 = f3;  in_funct7 = f7;  in_rd = rd;
      in_rs1_val = rs1;  in_rs2_val = rs2; in_imm = imm;
      in_valid   = 1'b1;
      check("in_ready_at_issue", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Called #1 after the accept edge; lat counts edges including the accept edge.
   task automatic wait_out(output int l);
      l = 1;
      while (!out_valid && l < 200) begin
         @(posedge clk); #1;
         l++;
      end
      check("out_valid_seen", 32'(out_valid), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0;
      in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
      mul_ready = 1'b0; mul_stale = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_alu_sel", 32'(alu_sel), 32'h0F);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // ADD 5+7
      issue(OPC_OP, 3'b000, F7_ZERO, 5'd1, 32'd5, 32'd7, 32'd0);
      check("add_sel_exec", 32'(alu_sel), 32'h00);
      check("add_a", alu_a, 32'd5);
      check("add_b", alu_b, 32'd7);
      check("add_busy", 32'(busy), 32'd1);
      wait_out(lat);
      check("add_latency", 32'(lat), 32'd2);
      check("add_result", out_result, 32'd12);
      check("add_rd", 32'(out_rd), 32'd1);
      check("add_resp_sel", 32'(alu_sel), 32'h0F);

      // SUB 5-7, issued back-to-back with the ADD response handshake
      issue(OPC_OP, 3'b000, F7_ALT, 5'd2, 32'd5, 32'd7, 32'd0);
      check("sub_sel", 32'(alu_sel), 32'h08);
      wait_out(lat);
      check("sub_result", out_result, 32'hFFFF_FFFE);

      // SRAI imm=0x401 on 0x80000000
      issue(OPC_OPIMM, 3'b101, F7_ALT, 5'd3, 32'h8000_0000, 32'h1234_5678, 32'h0000_0401);
      check("srai_sel", 32'(alu_sel), 32'h0D);
      check("srai_b_imm", alu_b, 32'h0000_0401);
      wait_out(lat);
      check("srai_result", out_result, 32'hC000_0000);

      // ANDI
      issue(OPC_OPIMM, 3'b111, 7'h7F, 5'd4, 32'h0000_F0F0, 32'd0, 32'hFFFF_FF3C);
      wait_out(lat);
      check("andi_result", out_result, 32'h0000_F030);
      check("andi_illegal", 32'(out_illegal), 32'd0);

      // MULH -> illegal
      issue(OPC_OP, 3'b001, F7_MULDIV, 5'd5, 32'd3, 32'd4, 32'd0);
      check("mulh_latency_valid", 32'(out_valid), 32'd1);
      check("mulh_illegal", 32'(out_illegal), 32'd1);
      check("mulh_result", out_result, 32'd0);
      check("mulh_sel_idle", 32'(alu_sel), 32'h0F);
      check("mulh_rd", 32'(out_rd), 32'd5);

      // Load opcode -> illegal
      issue(7'b0000011, 3'b010, F7_ZERO, 5'd6, 32'd1, 32'd1, 32'd0);
      check("load_illegal", 32'(out_illegal), 32'd1);
      check("load_timeout", 32'(out_timeout), 32'd0);
      @(posedge clk); #1;
      check("illegal_cleared", 32'(out_illegal), 32'd0);

      // MUL 3 * -4 with stale ready during MD_START
      mul_ready = 1'b1; mul_stale = 1'b1;
      issue(OPC_OP, 3'b000, F7_MULDIV, 5'd7, 32'd3, 32'hFFFF_FFFC, 32'd0);
      check("mul_sel_start", 32'(alu_sel), 32'h1E);
      @(posedge clk); #1;
      check("mul_stale_ignored", 32'(out_valid), 32'd0);
      check("mul_sel_wait", 32'(alu_sel), 32'h1E);
      mul_ready = 1'b0; mul_stale = 1'b0;
      repeat (16) @(posedge clk);
      #1 mul_ready = 1'b1;
      wait_out(lat);
      check("mul_result", out_result, 32'hFFFF_FFF4);
      check("mul_rd", 32'(out_rd), 32'd7);
      check("mul_timeout", 32'(out_timeout), 32'd0);

      // Second MUL accepted in the same edge as the first response handshake
      mul_ready = 1'b0;
      issue(OPC_OP, 3'b000, F7_MULDIV, 5'd8, 32'd6, 32'd7, 32'd0);
      check("mul2_sel_start", 32'(alu_sel), 32'h1E);
      check("mul2_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk); #1;
      check("mul_gap_ge1", 32'(last_gap >= 1), 32'd1);
      repeat (3) @(posedge clk);
      #1 mul_ready = 1'b1;
      wait_out(lat);
      check("mul2_result", out_result, 32'd42);

      // MUL that never completes
      mul_ready = 1'b0;
      issue(OPC_OP, 3'b000, F7_MULDIV, 5'd9, 32'd2, 32'd2, 32'd0);
      wait_out(lat);
      check("to_latency", 32'(lat), 32'd66);
      check("to_flag", 32'(out_timeout), 32'd1);
      check("to_result", out_result, 32'd0);
      check("to_illegal", 32'(out_illegal), 32'd0);
      @(posedge clk); #1;

      // Reset in MD_WAIT
      issue(OPC_OP, 3'b000, F7_MULDIV, 5'd10, 32'd5, 32'd5, 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_sel", 32'(alu_sel), 32'h0F);
      check("midrst_a", alu_a, 32'd0);
      check("midrst_rd", 32'(out_rd), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; mul_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("midrst_no_result", 32'(out_valid), 32'd0);

      // Writeback stall holds the response
      out_ready = 1'b0;
      issue(OPC_OP, 3'b100, F7_ZERO, 5'd11, 32'h0000_00FF, 32'h0000_0F0F, 32'd0);
      wait_out(lat);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_result", out_result, 32'h0000_0FF0);
         check("stall_rd", 32'(out_rd), 32'd11);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1 check("stall_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("stall_done_valid", 32'(out_valid), 32'd0);
      check("stall_done_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
